// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for processinho: owns the PC, reads instructions
// from program RAM and drives one-cycle Moore strobes into the datapath.
module control_unit #(
   parameter int                     ADDR_WIDTH = 8,
   parameter int                     DATA_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic                    i_run,
   input  logic [DATA_WIDTH-1:0]   i_ram_data_out,
   output logic                    o_ram_enable,
   output logic                    o_we,
   output logic [ADDR_WIDTH-1:0]   o_addr,
   output logic                    o_gp_read,
   output logic                    o_gp_write,
   output logic [3:0]              o_gp_addr,
   output logic                    o_grab_ula,
   output logic                    o_latch_ula,
   output logic [3:0]              o_ula_operation,
   output logic [DATA_WIDTH-1:0]   o_bus_out,
   output logic                    o_bus_drive,
   output logic                    o_pc_increment,
   output logic                    o_pc_load,
   output logic [ADDR_WIDTH-1:0]   o_pc,
   output logic                    o_halted,
   output logic                    o_illegal
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_FETCH_W = 4'd2,
      S_DECODE  = 4'd3,
      S_OPER    = 4'd4,
      S_OPER_W  = 4'd5,
      S_EXEC    = 4'd6,
      S_WB      = 4'd7,
      S_HALT    = 4'd8
   } state_t;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_ALU = 4'h2;
   localparam logic [3:0] OP_RD  = 4'h3;
   localparam logic [3:0] OP_JMP = 4'h4;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                  r_state;
   state_t                  w_next_state;
   logic [ADDR_WIDTH-1:0]   r_pc;
   logic [DATA_WIDTH-1:0]   r_ir;
   logic [DATA_WIDTH-1:0]   r_imm;
   logic [3:0]              w_op;
   logic [3:0]              w_arg;
   logic                    w_op_illegal;

   assign w_op         = r_ir[DATA_WIDTH-1 -: 4];
   assign w_arg        = r_ir[3:0];
   assign w_op_illegal = (w_op >= 4'h5) && (w_op <= 4'hE);

   assign o_addr = r_pc;
   assign o_pc   = r_pc;
   assign o_we   = 1'b0;

   // State register
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // PC, instruction and immediate registers; only the wait states capture RAM data
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_pc  <= RESET_PC;
         r_ir  <= '0;
         r_imm <= '0;
      end else begin
         case (r_state)
            S_FETCH_W: begin
               r_ir <= i_ram_data_out;
               r_pc <= r_pc + PC_ONE;
            end
            S_OPER_W: begin
               r_imm <= i_ram_data_out;
               if (w_op == OP_JMP) begin
                  r_pc <= i_ram_data_out[ADDR_WIDTH-1:0];
               end else begin
                  r_pc <= r_pc + PC_ONE;
               end
            end
            default: begin
               r_pc <= r_pc;
            end
         endcase
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_run) begin
               w_next_state = S_FETCH;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_FETCH:   w_next_state = S_FETCH_W;
         S_FETCH_W: w_next_state = S_DECODE;
         S_DECODE: begin
            case (w_op)
               OP_NOP:         w_next_state = S_FETCH;
               OP_LDI, OP_JMP: w_next_state = S_OPER;
               OP_ALU, OP_RD:  w_next_state = S_EXEC;
               OP_HLT:         w_next_state = S_HALT;
               default:        w_next_state = S_FETCH;
            endcase
         end
         S_OPER:   w_next_state = S_OPER_W;
         S_OPER_W: w_next_state = S_EXEC;
         S_EXEC: begin
            if (w_op == OP_ALU) begin
               w_next_state = S_WB;
            end else begin
               w_next_state = S_FETCH;
            end
         end
         S_WB:    w_next_state = S_FETCH;
         S_HALT:  w_next_state = S_HALT;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Moore output decode; every strobe is a pure function of the current state
   always_comb begin
      o_ram_enable    = 1'b0;
      o_gp_read       = 1'b0;
      o_gp_write      = 1'b0;
      o_gp_addr       = 4'h0;
      o_grab_ula      = 1'b0;
      o_latch_ula     = 1'b0;
      o_ula_operation = 4'h0;
      o_bus_out       = '0;
      o_bus_drive     = 1'b0;
      o_pc_increment  = 1'b0;
      o_pc_load       = 1'b0;
      o_halted        = 1'b0;
      o_illegal       = 1'b0;
      case (r_state)
         S_FETCH, S_OPER: begin
            o_ram_enable = 1'b1;
         end
         S_FETCH_W: begin
            o_pc_increment = 1'b1;
         end
         S_DECODE: begin
            if (w_op_illegal) begin
               o_illegal = 1'b1;
            end else begin
               o_illegal = 1'b0;
            end
         end
         S_OPER_W: begin
            if (w_op == OP_JMP) begin
               o_pc_load = 1'b1;
            end else begin
               o_pc_increment = 1'b1;
            end
         end
         S_EXEC: begin
            case (w_op)
               OP_LDI: begin
                  o_bus_out   = r_imm;
                  o_bus_drive = 1'b1;
                  o_gp_write  = 1'b1;
                  o_gp_addr   = w_arg;
               end
               OP_RD: begin
                  o_gp_read = 1'b1;
                  o_gp_addr = w_arg;
               end
               OP_ALU: begin
                  o_grab_ula      = 1'b1;
                  o_ula_operation = w_arg;
               end
               default: begin
                  o_gp_addr = 4'h0;
               end
            endcase
         end
         S_WB: begin
            o_latch_ula     = 1'b1;
            o_gp_write      = 1'b1;
            o_gp_addr       = 4'h0;
            o_ula_operation = w_arg;
         end
         S_HALT: begin
            o_halted = 1'b1;
         end
         default: begin
            o_halted = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a registered RAM model feeds hand-written
// programs and every check compares against hand-computed cycle-exact values.
module tb_control_unit;

   logic       clock;
   logic       reset;
   logic       run;
   logic [7:0] ram_data_out;
   logic       ram_enable;
   logic       we;
   logic [7:0] addr;
   logic       gp_read;
   logic       gp_write;
   logic [3:0] gp_addr;
   logic       grab_ula;
   logic       latch_ula;
   logic [3:0] ula_operation;
   logic [7:0] bus_out;
   logic       bus_drive;
   logic       pc_increment;
   logic       pc_load;
   logic [7:0] pc;
   logic       halted;
   logic       illegal;

   logic [7:0] mem [256];
   int total = 0;
   int bad   = 0;

   control_unit dut (
      .i_clock         (clock),
      .i_reset         (reset),
      .i_run           (run),
      .i_ram_data_out  (ram_data_out),
      .o_ram_enable    (ram_enable),
      .o_we            (we),
      .o_addr          (addr),
      .o_gp_read       (gp_read),
      .o_gp_write      (gp_write),
      .o_gp_addr       (gp_addr),
      .o_grab_ula      (grab_ula),
      .o_latch_ula     (latch_ula),
      .o_ula_operation (ula_operation),
      .o_bus_out       (bus_out),
      .o_bus_drive     (bus_drive),
      .o_pc_increment  (pc_increment),
      .o_pc_load       (pc_load),
      .o_pc            (pc),
      .o_halted        (halted),
      .o_illegal       (illegal)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Program RAM: read data appears the cycle after ram_enable
   always @(posedge clock) begin
      if (ram_enable) ram_data_out <= mem[addr];
   end

   function automatic logic [11:0] strobes();
      return {ram_enable, we, gp_read, gp_write, grab_ula, latch_ula,
              bus_drive, pc_increment, pc_load, halted, illegal, 1'b0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run   = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   logic [11:0] acc;
   int          ill_cnt;

   initial begin
      reset = 1'b1;
      run   = 1'b0;
      ram_data_out = 8'h00;
      clear_mem();
      tick();
      tick();
      chk("rst_strobes", {20'h0, strobes()}, 32'h0);
      chk("rst_pc", {24'h0, pc}, 32'h0);
      chk("rst_addr", {24'h0, addr}, 32'h0);
      chk("rst_fields", {16'h0, gp_addr, ula_operation, bus_out}, 32'h0);
      reset = 1'b0;
      tick();
      tick();
      chk("idle_no_run", {20'h0, strobes()}, 32'h0);

      // 1: NOP timing
      run = 1'b1;
      tick();
      chk("t1_c1_fetch", {23'h0, ram_enable, addr}, {23'h0, 1'b1, 8'h00});
      tick();
      chk("t1_c2_inc", {30'h0, pc_increment, ram_enable}, 32'h2);
      tick();
      chk("t1_c3_dec", {20'h0, strobes()}, 32'h0);
      chk("t1_c3_pc", {24'h0, pc}, 32'h1);
      tick();
      chk("t1_c4_fetch", {23'h0, ram_enable, addr}, {23'h0, 1'b1, 8'h01});

      // 2: LDI R3,#0x5A
      do_reset();
      mem[0] = 8'h13; mem[1] = 8'h5A;
      run = 1'b1;
      tick(); tick(); tick(); tick();
      chk("t2_c4_oper", {23'h0, ram_enable, addr}, {23'h0, 1'b1, 8'h01});
      tick();
      chk("t2_c5_inc", {30'h0, pc_increment, pc_load}, 32'h2);
      tick();
      chk("t2_c6_bus", {19'h0, bus_drive, gp_write, gp_read, latch_ula, bus_out},
          {19'h0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A});
      chk("t2_c6_gpaddr", {28'h0, gp_addr}, 32'h3);
      chk("t2_c6_pc", {24'h0, pc}, 32'h2);
      tick();
      chk("t2_c7_fetch", {22'h0, bus_drive, ram_enable, addr}, {22'h0, 1'b0, 1'b1, 8'h02});

      // 3: ALU op 7
      do_reset();
      clear_mem();
      mem[0] = 8'h27;
      run = 1'b1;
      tick(); tick(); tick(); tick();
      chk("t3_c4_grab", {26'h0, grab_ula, gp_write, ula_operation},
          {26'h0, 1'b1, 1'b0, 4'h7});
      tick();
      chk("t3_c5_wb", {24'h0, latch_ula, gp_write, bus_drive, grab_ula, gp_addr},
          {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0});
      chk("t3_c5_op", {28'h0, ula_operation}, 32'h7);
      tick();
      chk("t3_c6_fetch", {23'h0, ram_enable, addr}, {23'h0, 1'b1, 8'h01});

      // 4: JMP #0xFE and PC wrap
      do_reset();
      clear_mem();
      mem[0] = 8'h40; mem[1] = 8'hFE;
      run = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      chk("t4_c5_load", {30'h0, pc_load, pc_increment}, 32'h2);
      tick();
      chk("t4_c6_exec", {12'h0, strobes(), pc}, {12'h0, 12'h0, 8'hFE});
      tick();
      chk("t4_c7_fetch_fe", {23'h0, ram_enable, addr}, {23'h0, 1'b1, 8'hFE});
      tick(); tick(); tick();
      chk("t4_c10_fetch_ff", {23'h0, ram_enable, addr}, {23'h0, 1'b1, 8'hFF});
      tick(); tick(); tick();
      chk("t4_c13_wrap", {23'h0, ram_enable, addr}, {23'h0, 1'b1, 8'h00});

      // 5: HLT
      do_reset();
      clear_mem();
      mem[0] = 8'hF0;
      run = 1'b1;
      tick(); tick(); tick(); tick();
      chk("t5_c4_halted", {20'h0, strobes()}, 32'h4);
      acc = 12'h0;
      for (int i = 0; i < 20; i++) begin
         tick();
         acc = acc | (strobes() & 12'hFFB);
         if (!halted) acc = acc | 12'h004;
      end
      chk("t5_halt_quiet", {20'h0, acc}, 32'h0);
      do_reset();
      chk("t5_rst_exit", {12'h0, strobes(), pc}, 32'h0);
      tick();
      chk("t5_idle", {20'h0, strobes()}, 32'h0);

      // 6: reset during OPER_W of LDI, then an illegal opcode
      do_reset();
      clear_mem();
      mem[0] = 8'h13; mem[1] = 8'h5A;
      run = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      chk("t6_c5_operw", {31'h0, pc_increment}, 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      run   = 1'b0;
      acc = 12'h0;
      for (int i = 0; i < 6; i++) begin
         acc = acc | strobes();
         tick();
      end
      chk("t6_abort_quiet", {20'h0, acc}, 32'h0);
      chk("t6_abort_pc", {24'h0, pc}, 32'h0);
      mem[0] = 8'h90; mem[1] = 8'h00;
      run = 1'b1;
      ill_cnt = 0;
      tick();
      if (illegal) ill_cnt++;
      tick();
      if (illegal) ill_cnt++;
      tick();
      chk("t6_c3_illegal", {31'h0, illegal}, 32'h1);
      if (illegal) ill_cnt++;
      tick();
      chk("t6_c4_fetch", {23'h0, ram_enable, addr}, {23'h0, 1'b1, 8'h01});
      if (illegal) ill_cnt++;
      tick();
      if (illegal) ill_cnt++;
      tick();
      if (illegal) ill_cnt++;
      chk("t6_ill_pulses", ill_cnt, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
